// File: rtl/countdown_timer_if.sv
// Key inputs, seven-segment digits and status LEDs
// of the countdown timer board.
interface countdown_timer_if;
  logic       key_start_pause;
  logic       key_set_min;
  logic       key_set_sec;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic [6:0] hex4;
  logic [6:0] hex5;
  logic       led0;
  logic       led1;
  logic       led2;
  logic       led3;

  modport master (
    output key_start_pause, key_set_min, key_set_sec,
    input  hex0, hex1, hex2, hex3, hex4, hex5,
    input  led0, led1, led2, led3
  );

  modport slave (
    input  key_start_pause, key_set_min, key_set_sec,
    output hex0, hex1, hex2, hex3, hex4, hex5,
    output led0, led1, led2, led3
  );
endinterface

// File: rtl/countdown_timer.sv
// Preset MM:SS:CC countdown timer with debounced keys,
// BCD countdown, alarm LEDs and seven-segment display.
module countdown_timer #(
  parameter int TICK_DIV    = 500000,
  parameter int DEBOUNCE    = 1000000,
  parameter int BLINK_TICKS = 50
) (
  input logic              clk,
  input logic              key_reset,
  countdown_timer_if.slave io
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DB_HIT  = DW'(DEBOUNCE - 1);
  localparam logic [BW-1:0] BL_TOP  = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    ALARM
  } state_t;

  state_t          state;
  logic [2:0]      k_raw;
  logic [2:0]      s1;
  logic [2:0]      s2;
  logic [2:0]      ev;
  logic [DW-1:0]   db [3];
  logic [PW-1:0]   pre;
  logic            tick;
  logic [23:0]     cnt;
  logic [23:0]     cnt_dec;
  logic [23:0]     preset;
  logic [BW-1:0]   blink;
  logic            led_blink;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] inc_mm(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    return {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] inc_ss(input logic [7:0] v);
    if (v[3:0] != 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    return {(v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
  endfunction

  // One-centisecond decrement, borrowing cc -> ss -> mm.
  function automatic logic [23:0] dec(input logic [23:0] v);
    logic [3:0] m1, m0, t1, t0, c1, c0;
    {m1, m0, t1, t0, c1, c0} = v;
    if (c0 != 4'd0) c0 = c0 - 4'd1;
    else begin
      c0 = 4'd9;
      if (c1 != 4'd0) c1 = c1 - 4'd1;
      else begin
        c1 = 4'd9;
        if (t0 != 4'd0) t0 = t0 - 4'd1;
        else begin
          t0 = 4'd9;
          if (t1 != 4'd0) t1 = t1 - 4'd1;
          else begin
            t1 = 4'd5;
            if (m0 != 4'd0) m0 = m0 - 4'd1;
            else begin
              m0 = 4'd9;
              m1 = (m1 != 4'd0) ? m1 - 4'd1 : 4'd9;
            end
          end
        end
      end
    end
    return {m1, m0, t1, t0, c1, c0};
  endfunction

  assign k_raw = {io.key_set_sec, io.key_set_min,
                  io.key_start_pause};

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      s1 <= 3'b111;
      s2 <= 3'b111;
    end else begin
      s1 <= k_raw;
      s2 <= s1;
    end
  end

  // Counter saturates at DB_MAX so a held key fires once.
  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      ev <= '0;
      for (int i = 0; i < 3; i++) db[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ev[i] <= !s2[i] && (db[i] == DB_HIT);
        if (s2[i])
          db[i] <= '0;
        else if (db[i] != DB_MAX)
          db[i] <= db[i] + 1'b1;
      end
    end
  end

  assign tick = ((state == RUN) || (state == ALARM))
             && (pre == PRE_TOP);
  assign cnt_dec = dec(cnt);

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset)
      pre <= '0;
    else if ((state == IDLE) && ev[0] && (cnt != '0))
      pre <= '0;
    else if ((state == RUN) || (state == ALARM))
      pre <= tick ? '0 : pre + 1'b1;
  end

  always_ff @(posedge clk or negedge key_reset) begin
    if (!key_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      preset    <= '0;
      blink     <= '0;
      led_blink <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ev[0]) begin
            if (cnt != '0) begin
              preset <= cnt;
              state  <= RUN;
            end
          end else begin
            if (ev[1])
              cnt[23:16] <= inc_mm(cnt[23:16]);
            if (ev[2]) begin
              cnt[15:8] <= inc_ss(cnt[15:8]);
              cnt[7:0]  <= '0;
            end
          end
        end
        RUN: begin
          if (tick) cnt <= cnt_dec;
          if (tick && (cnt_dec == '0)) begin
            state     <= ALARM;
            blink     <= '0;
            led_blink <= 1'b0;
          end else if (ev[0]) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (ev[0]) state <= RUN;
        end
        ALARM: begin
          if (|ev) begin
            cnt       <= preset;
            led_blink <= 1'b0;
            state     <= IDLE;
          end else if (tick) begin
            if (blink == BL_TOP) begin
              blink     <= '0;
              led_blink <= ~led_blink;
            end else begin
              blink <= blink + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.hex5 = seg(cnt[23:20]);
  assign io.hex4 = seg(cnt[19:16]);
  assign io.hex3 = seg(cnt[15:12]);
  assign io.hex2 = seg(cnt[11:8]);
  assign io.hex1 = seg(cnt[7:4]);
  assign io.hex0 = seg(cnt[3:0]);

  assign io.led0 = (state == RUN);
  assign io.led1 = (state == ALARM);
  assign io.led2 = (state == PAUSE);
  assign io.led3 = led_blink;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with small
// TICK_DIV / DEBOUNCE / BLINK_TICKS values.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic key_reset;
  int   n_chk = 0;
  int   n_fail = 0;

  countdown_timer_if bus ();

  countdown_timer #(
    .TICK_DIV(4),
    .DEBOUNCE(3),
    .BLINK_TICKS(2)
  ) dut (
    .clk(clk),
    .key_reset(key_reset),
    .io(bus)
  );

  always #5 clk = ~clk;

  logic [41:0] hex;
  logic [3:0]  leds;
  assign hex  = {bus.hex5, bus.hex4, bus.hex3,
                 bus.hex2, bus.hex1, bus.hex0};
  assign leds = {bus.led3, bus.led2, bus.led1, bus.led0};

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int m, s, c);
    return {seg7(m / 10), seg7(m % 10), seg7(s / 10),
            seg7(s % 10), seg7(c / 10), seg7(c % 10)};
  endfunction

  function automatic logic [41:0] disp_cs(input int cs);
    return disp(cs / 6000, (cs / 100) % 60, cs % 100);
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: bus.key_start_pause = v;
      1: bus.key_set_min = v;
      default: bus.key_set_sec = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b0);
    repeat (8) @(negedge clk);
    set_key(k, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_led(input string tag, input int b);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (leds[b]) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int  run_edges;
    int  r;
    int  ticks;
    bit  prev;
    bit  ok;

    key_reset           = 1'b0;
    bus.key_start_pause = 1'b1;
    bus.key_set_min     = 1'b1;
    bus.key_set_sec     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hex", 64'(hex), 64'(disp(0, 0, 0)));
    check("rst_led", 64'(leds), 64'd0);
    key_reset = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_hex", 64'(hex), 64'(disp(0, 0, 0)));
    check("idle_led", 64'(leds), 64'd0);

    for (int i = 0; i < 5; i++) begin
      bus.key_set_sec = 1'b0;
      repeat (2) @(negedge clk);
      bus.key_set_sec = 1'b1;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce", 64'(hex), 64'(disp(0, 0, 0)));

    repeat (2) press(1);
    repeat (3) press(2);
    check("set_020300", 64'(hex), 64'(disp(2, 3, 0)));
    repeat (97) press(1);
    check("mm_99", 64'(hex), 64'(disp(99, 3, 0)));
    press(1);
    check("mm_wrap", 64'(hex), 64'(disp(0, 3, 0)));
    repeat (56) press(2);
    check("ss_59", 64'(hex), 64'(disp(0, 59, 0)));
    press(2);
    check("ss_wrap", 64'(hex), 64'(disp(0, 0, 0)));

    press(0);
    repeat (4) @(negedge clk);
    check("start_zero_led", 64'(leds), 64'd0);
    check("start_zero_hex", 64'(hex), 64'(disp(0, 0, 0)));

    press(2);
    check("preset_1s", 64'(hex), 64'(disp(0, 1, 0)));
    set_key(0, 1'b0);
    wait_led("run3_wait", 0);
    set_key(0, 1'b1);
    check("run3_led", 64'(leds), 64'b0001);
    check("run3_hex0", 64'(hex), 64'(disp(0, 1, 0)));
    repeat (3) @(negedge clk);
    check("run3_pre3", 64'(hex), 64'(disp(0, 1, 0)));
    @(negedge clk);
    check("run3_tick1", 64'(hex), 64'(disp(0, 0, 99)));
    repeat (395) @(negedge clk);
    check("run3_last", 64'(hex), 64'(disp(0, 0, 1)));
    check("run3_last_led", 64'(leds), 64'b0001);
    @(negedge clk);
    check("alarm_hex", 64'(hex), 64'(disp(0, 0, 0)));
    check("alarm_led", 64'(leds), 64'b0010);

    repeat (7) @(negedge clk);
    check("blink_lo7", 64'(leds), 64'b0010);
    @(negedge clk);
    check("blink_hi8", 64'(leds), 64'b1010);
    repeat (7) @(negedge clk);
    check("blink_hi15", 64'(leds), 64'b1010);
    @(negedge clk);
    check("blink_lo16", 64'(leds), 64'b0010);
    press(1);
    check("ack_hex", 64'(hex), 64'(disp(0, 1, 0)));
    check("ack_led", 64'(leds), 64'd0);

    press(1);
    repeat (59) press(2);
    check("preset_1m", 64'(hex), 64'(disp(1, 0, 0)));
    set_key(0, 1'b0);
    wait_led("run4_wait", 0);
    set_key(0, 1'b1);
    repeat (4) @(negedge clk);
    check("run4_tick1", 64'(hex), 64'(disp(0, 59, 99)));

    set_key(0, 1'b0);
    run_edges = 0;
    prev      = leds[0];
    ok        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev) run_edges++;
      prev = leds[0];
      if (leds[2]) begin
        ok = 1'b1;
        break;
      end
    end
    set_key(0, 1'b1);
    check("pause_wait", 64'(ok), 64'd1);
    ticks = run_edges / 4;
    r     = run_edges % 4;
    check("pause_led", 64'(leds), 64'b0100);
    check("pause_hex", 64'(hex), 64'(disp_cs(5999 - ticks)));
    repeat (20) @(negedge clk);
    check("frozen20", 64'(hex), 64'(disp_cs(5999 - ticks)));
    repeat (20) @(negedge clk);
    check("frozen40", 64'(hex), 64'(disp_cs(5999 - ticks)));
    check("frozen_led", 64'(leds), 64'b0100);

    set_key(0, 1'b0);
    wait_led("resume_wait", 0);
    set_key(0, 1'b1);
    if (4 - r > 1) begin
      repeat (4 - r - 1) @(negedge clk);
      check("resume_early", 64'(hex),
            64'(disp_cs(5999 - ticks)));
    end
    @(negedge clk);
    check("resume_tick", 64'(hex),
          64'(disp_cs(5999 - ticks - 1)));

    key_reset = 1'b0;
    repeat (3) @(negedge clk);
    key_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_hex", 64'(hex), 64'(disp(0, 0, 0)));
    press(2);
    set_key(0, 1'b0);
    wait_led("run6_wait", 0);
    set_key(0, 1'b1);
    repeat (200) @(negedge clk);
    check("run6_50", 64'(hex), 64'(disp(0, 0, 50)));
    check("run6_led", 64'(leds), 64'b0001);
    #2 key_reset = 1'b0;
    #1;
    check("async_hex", 64'(hex), 64'(disp(0, 0, 0)));
    check("async_led", 64'(leds), 64'd0);
    @(negedge clk);
    key_reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_led", 64'(leds), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Companion to the stopwatch: a preset-and-count-down timer for the same board, using the same keys, six seven-segment digits and four LEDs. The user sets a preset time with two keys. The timer then counts down in centiseconds from MM:SS:CC to 00:00:00 and raises an alarm on the LEDs. Display layout is minute-high on hex5 through centisecond-low on hex0, with the same active-low segment encoding as the stopwatch.

Parameters:
TICK_DIV, 500000, clk cycles per centisecond tick (10 ms at 50 MHz)
DEBOUNCE, 1000000, consecutive stable-low cycles required to accept a key press
BLINK_TICKS, 50, ticks per led3 toggle while in ALARM

Ports:
clk  input  1  system clock
key_reset  input  1  asynchronous active-low reset
key_start_pause  input  1  active-low push button: start/pause/acknowledge
key_set_min  input  1  active-low push button: increment preset minutes
key_set_sec  input  1  active-low push button: increment preset seconds
hex0..hex5  output  7 each  active-low segments; hex5/hex4 = minutes, hex3/hex2 = seconds, hex1/hex0 = centiseconds
led0  output  1  high in RUN
led1  output  1  high in ALARM
led2  output  1  high in PAUSE
led3  output  1  blinks in ALARM, low otherwise

Behaviour:
- Reset (key_reset low, asynchronous):
  - state IDLE; counter and preset digits all 0; prescaler 0; debouncers cleared; led0..3 = 0.
  - All hex outputs = 7'b100_0000 (digit 0).
- Segment encoding per digit 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any other code gives 1111111. Digit outputs are combinational from the counter digits.
- Key inputs:
  - Each key is 2-FF synchronised, then debounced.
  - A per-key counter increments while the synced key is low and clears while it is high.
  - A single one-cycle press event fires when the counter reaches DEBOUNCE. The counter saturates there, so one event per press; holding the key gives no repeat.
- Prescaler:
  - Runs only in RUN and ALARM.
  - On the cycle it equals TICK_DIV-1, emit tick and wrap to 0.
  - Held in PAUSE.
  - Cleared on IDLE->RUN.
- Counter: BCD digits, mm 00..99, ss 00..59, cc 00..99.
- States:
  - IDLE:
    - set_min event: mm += 1, 99 wraps to 00.
    - set_sec event: ss += 1, 59 wraps to 00. cc forced 00.
    - start event with counter nonzero: copy counter to preset, go to RUN.
    - start event with counter 00:00:00: ignored.
    - start and set events in the same cycle: start wins, set ignored.
  - RUN:
    - Each tick decrements by one centisecond with BCD borrow (cc 00 -> 99 borrows ss; ss 00 -> 59 borrows mm).
    - A tick that produces 00:00:00 enters ALARM on the same edge.
    - start event: go to PAUSE. If a tick coincides with it, the decrement is still applied.
    - If that tick reaches zero, ALARM takes priority over PAUSE.
    - Set keys ignored.
  - PAUSE:
    - Counter frozen.
    - start event: go to RUN, prescaler resumes from its held value.
    - Set keys ignored.
  - ALARM:
    - Counter stays 00:00:00.
    - led3 toggles every BLINK_TICKS ticks, starting low.
    - Any key event: reload counter from preset, led3 = 0, go to IDLE. This re-arms the same time.
- Reset asserted mid-RUN/ALARM: immediate return to reset values; preset is lost.

Test Plan:
Run all scenarios with TICK_DIV=4, DEBOUNCE=3, BLINK_TICKS=2.
1. Reset, then idle 20 cycles -> all hex = 1000000, led0..3 = 0. Bounce key_set_sec low 2 cycles / high 1, repeated 5 times -> no change to ss.
2. In IDLE: 2 set_min presses, 3 set_sec presses -> display 02:03:00. 100 set_min presses from 00 -> mm 00. 60 set_sec presses -> ss 00.
3. Preset 00:01:00, start -> led0 = 1. After exactly 4 clk cycles per tick, one tick gives 00:00:99. After 100 ticks -> 00:00:00, led0 = 0, led1 = 1 on the same edge as the final tick.
4. Preset 01:00:00, start, 1 tick -> 00:59:99. Press start -> led2 = 1, display frozen for 40 cycles. Press start -> resume; next tick arrives at the remaining prescaler count.
5. In ALARM: led3 toggles every 8 cycles. Press set_min -> IDLE with display restored to the preset (00:01:00), led1 = led3 = 0.
6. Start pressed on 00:00:00 in IDLE -> stays IDLE, led0 = 0. Assert key_reset mid-RUN at 00:00:50 -> outputs at reset values immediately, without waiting for a clk edge.
